at_seq: RTL and testbench

AT_SEQ -- requirements
Module: at_seq

---
 rtl/at_seq.sv | 211 +++++++++++++++++++++
 tb/tb_at_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/at_seq.sv
// -----------------------------------------------------------------------------
// at_seq -- sequencer for a 16-bit 74194-style universal shift register (AT).
//
// Runs one load, shift-right, shift-left or rotate-right operation on the
// external AT register. For each step it sets the mode select and serial
// input one cycle early, then pulses the register strobe. It also tracks the
// bits that fall off the end of the register.
//
// Ports
//   clk_sys   in   system clock, rising edge
//   clr_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only when idle
//   op[1:0]   in   00 load, 01 shift right, 10 shift left, 11 rotate right
//   cnt[3:0]  in   shift step count, 0 means 16 (ignored for load)
//   fill      in   serial bit injected for shift right / shift left
//   at_lsb    in   AT bit 0 read back from the register
//   at_msb    in   AT bit 15 read back from the register
//   s1, s0    out  AT mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   sl        out  serial bit into AT
//   c         out  AT strobe, the register acts on its rising edge
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   last_out  out  last bit shifted out of AT
//   any_out   out  sticky OR of all bits shifted out during the operation
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | outputs quiet; waits for start and captures op/cnt/fill
// SET    | drives mode and sl for the next step, samples the outgoing bit
// PULSE  | raises c with mode/sl held, counts the step
// DONE   | one-cycle done pulse, then back to IDLE
//
// Each state's outputs are registered at the clock edge where that state is
// executed. As a result, the mode settles a full cycle before c rises, and c
// always falls between two steps.
// -----------------------------------------------------------------------------
module at_seq (
    input  logic       clk_sys,
    input  logic       clr_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] cnt,
    input  logic       fill,
    input  logic       at_lsb,
    input  logic       at_msb,
    output logic       s1,
    output logic       s0,
    output logic       sl,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       last_out,
    output logic       any_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t     state_q;
    logic [1:0] op_q;
    logic       fill_q;
    logic [4:0] steps_q;        // one bit wider than cnt so that 0 maps to 16
    logic [1:0] mode_q;
    logic       sl_q;
    logic       c_q;
    logic       busy_q;
    logic       done_q;
    logic       last_q;
    logic       any_q;

    logic [1:0] mode_d;
    logic       sl_d;
    logic       out_bit_d;      // bit about to leave AT on the coming step
    logic [4:0] steps_d;        // step count for a newly accepted start

    // Mode, serial input and outgoing bit for the captured operation.
    // Rotate right uses the shift-right mode and feeds bit 0 back into bit 15.
    always_comb begin
        mode_d    = MODE_HOLD;
        sl_d      = 1'b0;
        out_bit_d = 1'b0;
        unique case (op_q)
            OP_LOAD: begin
                mode_d    = MODE_LOAD;
                sl_d      = 1'b0;
                out_bit_d = 1'b0;
            end
            OP_SHR: begin
                mode_d    = MODE_SHR;
                sl_d      = fill_q;
                out_bit_d = at_lsb;
            end
            OP_SHL: begin
                mode_d    = MODE_SHL;
                sl_d      = fill_q;
                out_bit_d = at_msb;
            end
            OP_ROR: begin
                mode_d    = MODE_SHR;
                sl_d      = at_lsb;
                out_bit_d = at_lsb;
            end
            default: begin
                mode_d    = MODE_HOLD;
                sl_d      = 1'b0;
                out_bit_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        steps_d = {1'b0, cnt};
        if (op == OP_LOAD) begin
            steps_d = 5'd1;
        end else if (cnt == 4'd0) begin
            steps_d = 5'd16;
        end
    end

    always_ff @(posedge clk_sys or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
            steps_q <= 5'd0;
            mode_q  <= MODE_HOLD;
            sl_q    <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    mode_q <= MODE_HOLD;
                    sl_q   <= 1'b0;
                    c_q    <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        fill_q  <= fill;
                        steps_q <= steps_d;
                        last_q  <= 1'b0;
                        any_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SET;
                    end
                end
                ST_SET: begin
                    mode_q <= mode_d;
                    sl_q   <= sl_d;
                    c_q    <= 1'b0;
                    busy_q <= 1'b1;
                    if (op_q != OP_LOAD) begin
                        last_q <= out_bit_d;
                        any_q  <= any_q | out_bit_d;
                    end
                    state_q <= ST_PULSE;
                end
                ST_PULSE: begin
                    // mode_q and sl_q keep their SET values while c is high
                    c_q     <= 1'b1;
                    busy_q  <= 1'b1;
                    steps_q <= steps_q - 5'd1;
                    if ((steps_q == 5'd1) || (op_q == OP_LOAD)) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SET;
                    end
                end
                ST_DONE: begin
                    mode_q  <= MODE_HOLD;
                    sl_q    <= 1'b0;
                    c_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s1       = mode_q[1];
    assign s0       = mode_q[0];
    assign sl       = sl_q;
    assign c        = c_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign last_out = last_q;
    assign any_out  = any_q;

endmodule

// File: tb/tb_at_seq.sv
// -----------------------------------------------------------------------------
// tb_at_seq -- directed bench for at_seq driving a behavioural 74194-style
// 16-bit register. Each task runs one scenario against hand-computed values.
// -----------------------------------------------------------------------------
module tb_at_seq;

    logic       clk_sys = 1'b0;
    logic       clr_n   = 1'b0;
    logic       start   = 1'b0;
    logic [1:0] op      = 2'b00;
    logic [3:0] cnt     = 4'd0;
    logic       fill    = 1'b0;
    logic       at_lsb;
    logic       at_msb;
    logic       s1, s0, sl, c, busy, done, last_out, any_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    at_seq dut (
        .clk_sys  (clk_sys),
        .clr_n    (clr_n),
        .start    (start),
        .op       (op),
        .cnt      (cnt),
        .fill     (fill),
        .at_lsb   (at_lsb),
        .at_msb   (at_msb),
        .s1       (s1),
        .s0       (s0),
        .sl       (sl),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .last_out (last_out),
        .any_out  (any_out)
    );

    // Behavioural AT register: acts on the rising edge of c.
    logic [15:0] at_q      = 16'h0000;
    logic [15:0] pdata     = 16'h0000;
    int          pulse_cnt = 0;
    logic [2:0]  mode_at_c = 3'b000;

    always @(posedge c) begin
        pulse_cnt <= pulse_cnt + 1;
        mode_at_c <= {s1, s0, sl};
        case ({s1, s0})
            2'b01:   at_q <= {sl, at_q[15:1]};
            2'b10:   at_q <= {at_q[14:0], sl};
            2'b11:   at_q <= pdata;
            default: at_q <= at_q;
        endcase
    end

    assign at_lsb = at_q[0];
    assign at_msb = at_q[15];

    // Strobe monitor: while c is high, mode/sl must equal their values one
    // cycle earlier and c must not have been high then.
    logic       prev_c = 1'b0;
    logic [2:0] prev_m = 3'b000;

    always @(negedge clk_sys) begin
        if (c) begin
            checks++;
            if (prev_c !== 1'b0 || {s1, s0, sl} !== prev_m) begin
                errors++;
                $display("FAIL c_stable: prev_c=%b mode_sl=%b prev_mode_sl=%b (need prev_c=0, mode unchanged)",
                         prev_c, {s1, s0, sl}, prev_m);
            end
        end
        prev_c <= c;
        prev_m <= {s1, s0, sl};
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Starts one operation and measures it. lat is the number of clock edges
    // from the accepting edge T to the edge that raises done (999 = timeout).
    task automatic run_op(input logic [1:0] o, input logic [3:0] n, input logic f,
                          input bit poke, output int lat, output int pulses,
                          output logic busy_t, output logic [3:0] done_flags,
                          output logic done_after);
        int p0;
        @(posedge clk_sys); #1;
        op    = o;
        cnt   = n;
        fill  = f;
        start = 1'b1;
        @(posedge clk_sys); #1;
        p0     = pulse_cnt;
        busy_t = busy;
        if (poke) begin
            op   = ~o;
            cnt  = 4'd1;
            fill = ~f;
        end else begin
            start = 1'b0;
        end
        lat        = 999;
        done_flags = 4'hF;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_sys); #1;
            if (done === 1'b1) begin
                lat        = i;
                done_flags = {s1, s0, c, busy};
                start      = 1'b0;
                break;
            end
        end
        start  = 1'b0;
        pulses = pulse_cnt - p0;
        @(posedge clk_sys); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++;
        if ({s1, s0, sl, c} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mode: s1s0 sl c=%b need 0000", {s1, s0, sl, c});
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: busy done=%b need 00", {busy, done});
        end
        checks++;
        if ({last_out, any_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: last any=%b need 00", {last_out, any_out});
        end
        #2 clr_n = 1'b1;
    endtask

    task automatic test_load();
        int lat, pulses;
        logic bt, da;
        logic [3:0] df;
        pdata = 16'hCCAA;
        run_op(2'b00, 4'd7, 1'b1, 1'b0, lat, pulses, bt, df, da);
        checks++;
        if (bt !== 1'b1) begin errors++; $display("FAIL load_busy: busy=%b need 1", bt); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL load_latency: got %0d need 3", lat); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL load_pulses: got %0d need 1", pulses); end
        checks++;
        if (mode_at_c !== 3'b110) begin errors++; $display("FAIL load_mode: s1s0sl=%b need 110", mode_at_c); end
        checks++;
        if (at_q !== 16'hCCAA) begin errors++; $display("FAIL load_at: got %h need ccaa", at_q); end
        checks++;
        if ({last_out, any_out} !== 2'b00) begin
            errors++; $display("FAIL load_flags: last any=%b need 00", {last_out, any_out});
        end
        checks++;
        if ({df, da} !== 5'b00000) begin
            errors++; $display("FAIL load_done_state: s1s0 c busy=%b done_next=%b need 0000/0", df, da);
        end
    endtask

    task automatic test_shift_right();
        int lat, pulses;
        logic bt, da;
        logic [3:0] df;
        run_op(2'b01, 4'd2, 1'b0, 1'b0, lat, pulses, bt, df, da);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL shr_latency: got %0d need 5", lat); end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL shr_pulses: got %0d need 2", pulses); end
        checks++;
        if (mode_at_c !== 3'b010) begin errors++; $display("FAIL shr_mode: s1s0sl=%b need 010", mode_at_c); end
        checks++;
        if (at_q !== 16'h332A) begin errors++; $display("FAIL shr_at: got %h need 332a", at_q); end
        checks++;
        if ({last_out, any_out} !== 2'b11) begin
            errors++; $display("FAIL shr_flags: last any=%b need 11", {last_out, any_out});
        end
    endtask

    task automatic test_shift_left();
        int lat, pulses;
        logic bt, da;
        logic [3:0] df;
        pdata = 16'h8000;
        run_op(2'b00, 4'd0, 1'b0, 1'b0, lat, pulses, bt, df, da);
        run_op(2'b10, 4'd1, 1'b1, 1'b0, lat, pulses, bt, df, da);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL shl1_latency: got %0d need 3", lat); end
        checks++;
        if (at_q !== 16'h0001) begin errors++; $display("FAIL shl1_at: got %h need 0001", at_q); end
        checks++;
        if (last_out !== 1'b1) begin errors++; $display("FAIL shl1_last: got %b need 1", last_out); end
        run_op(2'b10, 4'd3, 1'b0, 1'b0, lat, pulses, bt, df, da);
        checks++;
        if (lat != 7 || pulses != 3) begin
            errors++; $display("FAIL shl3_timing: lat=%0d pulses=%0d need 7/3", lat, pulses);
        end
        checks++;
        if (at_q !== 16'h0008) begin errors++; $display("FAIL shl3_at: got %h need 0008", at_q); end
        checks++;
        if ({last_out, any_out} !== 2'b00) begin
            errors++; $display("FAIL shl3_flags: last any=%b need 00", {last_out, any_out});
        end
    endtask

    task automatic test_rotate();
        int lat, pulses;
        logic bt, da;
        logic [3:0] df;
        pdata = 16'h0001;
        run_op(2'b00, 4'd0, 1'b0, 1'b0, lat, pulses, bt, df, da);
        run_op(2'b11, 4'd0, 1'b0, 1'b0, lat, pulses, bt, df, da);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL ror_latency: got %0d need 33", lat); end
        checks++;
        if (pulses != 16) begin errors++; $display("FAIL ror_pulses: got %0d need 16", pulses); end
        checks++;
        if (at_q !== 16'h0001) begin errors++; $display("FAIL ror_at: got %h need 0001", at_q); end
        checks++;
        if ({last_out, any_out} !== 2'b01) begin
            errors++; $display("FAIL ror_flags: last any=%b need 01", {last_out, any_out});
        end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL ror_done_width: done next cycle=%b need 0", da); end
        repeat (5) @(posedge clk_sys);
        #1;
        checks++;
        if ({busy, last_out, any_out} !== 3'b001) begin
            errors++; $display("FAIL ror_hold: busy last any=%b need 001", {busy, last_out, any_out});
        end
    endtask

    task automatic test_back_to_back();
        int lat, pulses;
        logic bt, da;
        logic [3:0] df;
        pdata = 16'h00F0;
        run_op(2'b00, 4'd0, 1'b0, 1'b0, lat, pulses, bt, df, da);
        // start stays high with different op/cnt/fill through busy and DONE
        run_op(2'b01, 4'd3, 1'b1, 1'b1, lat, pulses, bt, df, da);
        checks++;
        if (lat != 7 || pulses != 3) begin
            errors++; $display("FAIL b2b_timing: lat=%0d pulses=%0d need 7/3", lat, pulses);
        end
        checks++;
        if (at_q !== 16'hE01E) begin errors++; $display("FAIL b2b_at: got %h need e01e", at_q); end
        checks++;
        if ({last_out, any_out} !== 2'b00) begin
            errors++; $display("FAIL b2b_flags: last any=%b need 00", {last_out, any_out});
        end
        checks++;
        if ({da, busy} !== 2'b00) begin
            errors++; $display("FAIL b2b_not_queued: done busy=%b need 00", {da, busy});
        end
    endtask

    task automatic test_abort();
        bit   seen_c;
        bit   seen_done;
        int   lat;
        @(posedge clk_sys); #1;
        op    = 2'b01;
        cnt   = 4'd4;
        fill  = 1'b1;
        start = 1'b1;
        @(posedge clk_sys); #1;
        start  = 1'b0;
        seen_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_sys); #1;
            if (c === 1'b1) begin
                seen_c = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen_c) begin errors++; $display("FAIL abort_pulse: c=%b never seen high, need 1", c); end
        #1 clr_n = 1'b0;
        #1;
        checks++;
        if ({s1, s0, sl, c, busy} !== 5'b00000) begin
            errors++; $display("FAIL abort_outputs: s1s0 sl c busy=%b need 00000", {s1, s0, sl, c, busy});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_sys); #1;
            if (done !== 1'b0) seen_done = 1'b1;
        end
        // release reset and request a load for the very next edge
        pdata = 16'hA5A5;
        op    = 2'b00;
        start = 1'b1;
        clr_n = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart: busy=%b need 1", busy); end
        lat = 999;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_sys); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (i == 1 && seen_done) lat = 998;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL abort_no_done: done pulsed=1 need 0"); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL abort_reload_latency: got %0d need 3", lat); end
        checks++;
        if (at_q !== 16'hA5A5) begin errors++; $display("FAIL abort_reload_at: got %h need a5a5", at_q); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left();
        test_rotate();
        test_back_to_back();
        test_abort();
        repeat (2) @(posedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
